// File: rtl/corr_peak_detect.sv
`default_nettype none
// ============================================================================
// Module   : corr_peak_detect
// Purpose  : Peak finder for the signed correlator stream. Arms when a valid
//            sample reaches the threshold, tracks the running maximum and
//            emits a one-cycle detect strobe with the peak value and its
//            sample position once HOLD valid samples pass without a new
//            maximum. A DEAD-sample hold-off then suppresses re-arming.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            ena        - global clock enable (low = every register holds)
//            in         - signed 14-bit correlation sample
//            in_vld     - in carries a new sample this cycle
//            threshold  - signed arming threshold (used only while idle)
//            detect     - registered one-enabled-cycle peak strobe
//            peak       - peak value, updated only with detect
//            peak_pos   - sample position of the peak, updated with detect
//            busy       - high while tracking or in hold-off
// Revision : 1.0 - initial release
// ============================================================================
module corr_peak_detect #(
  parameter int HOLD = 4,
  parameter int DEAD = 8,
  parameter int CW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic signed [13:0]  in,
  input  logic                in_vld,
  input  logic signed [13:0]  threshold,
  output logic                detect,
  output logic signed [13:0]  peak,
  output logic [CW-1:0]       peak_pos,
  output logic                busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TRACK   = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  localparam logic [7:0] HOLD_C    = 8'(HOLD);
  localparam logic [7:0] DEAD_C    = 8'(DEAD);
  localparam logic       DEAD_ZERO = (DEAD == 0);

  logic [1:0]         state;
  logic [CW-1:0]      pos;
  logic signed [13:0] max_val;
  logic [CW-1:0]      max_pos;
  logic [7:0]         hold_cnt;
  logic [7:0]         dead_cnt;

  // Counters never exceed their limits (<= 255), so 8-bit increments
  // cannot wrap before the equality compare.
  logic [7:0] hold_nxt;
  logic [7:0] dead_nxt;

  assign hold_nxt = hold_cnt + 8'd1;
  assign dead_nxt = dead_cnt + 8'd1;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pos      <= '0;
      max_val  <= '0;
      max_pos  <= '0;
      hold_cnt <= '0;
      dead_cnt <= '0;
      detect   <= 1'b0;
      peak     <= '0;
      peak_pos <= '0;
    end else if (ena) begin
      // Strobe lasts exactly one enabled cycle; set again below if needed.
      detect <= 1'b0;
      if (in_vld) begin
        pos <= pos + CW'(1);
        case (state)
          S_IDLE: begin
            if (in >= threshold) begin
              max_val  <= in;
              max_pos  <= pos;
              hold_cnt <= '0;
              state    <= S_TRACK;
            end
          end
          S_TRACK: begin
            // Strictly greater: on ties the earliest sample keeps the peak.
            if (in > max_val) begin
              max_val  <= in;
              max_pos  <= pos;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_nxt;
              if (hold_nxt == HOLD_C) begin
                detect   <= 1'b1;
                peak     <= max_val;
                peak_pos <= max_pos;
                dead_cnt <= '0;
                state    <= DEAD_ZERO ? S_IDLE : S_HOLDOFF;
              end
            end
          end
          S_HOLDOFF: begin
            // Sample values are ignored here, only counted.
            dead_cnt <= dead_nxt;
            if (dead_nxt == DEAD_C) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/corr_peak_detect.md
# corr_peak_detect

Peak finder between the correlator accumulator and the result output register. It consumes the signed 14-bit correlation stream and arms when a sample reaches a programmable threshold. It then tracks the local maximum until no larger sample has arrived for HOLD samples, and issues a one-cycle `detect` strobe carrying the peak value and its sample position. That strobe and value drive the output register's `detect`/`in` inputs directly.

## Interface
- HOLD, 4: number of consecutive valid samples without a new maximum that confirms a peak (1..255)
- DEAD, 8: valid samples ignored after a detect before re-arming (0..255)
- CW, 16: width of the free-running sample position counter
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- ena  in  1  global clock enable; when low, every register holds its value
- in  in  14  signed correlation sample (two's complement)
- in_vld  in  1  `in` is a new sample this cycle
- threshold  in  14  signed arming threshold; sampled only in IDLE
- detect  out  1  registered one-cycle peak strobe
- peak  out  14  signed peak value; valid when `detect`=1, held afterwards
- peak_pos  out  CW  sample counter value of the peak sample; valid when `detect`=1, held afterwards
- busy  out  1  high in TRACK or HOLDOFF

## Operation
- All state advances only on cycles with ena=1. Sample-driven actions additionally require in_vld=1.
- The sample counter `pos` increments on every valid sample and wraps modulo 2^CW. Each sample is tagged with the pre-increment value (the first sample after reset has pos 0).
- Comparisons are signed 14-bit. No arithmetic is done on sample values, so no overflow handling is needed.
- FSM states:
  - IDLE: on a valid sample with in >= threshold: max <= in, max_pos <= pos, hold_cnt <= 0, go to TRACK. Otherwise stay.
  - TRACK, on each valid sample:
    - in > max: max <= in, max_pos <= pos, hold_cnt <= 0.
    - Otherwise: hold_cnt <= hold_cnt+1.
    - Ties (in == max) do not update, so the first occurrence wins.
    - Samples below threshold still count toward hold.
    - When the increment makes hold_cnt == HOLD: detect <= 1, peak <= max, peak_pos <= max_pos, dead_cnt <= 0, go to HOLDOFF. If DEAD == 0, go to IDLE instead.
  - HOLDOFF, on each valid sample: dead_cnt <= dead_cnt+1. Sample values are ignored, including any above threshold. When dead_cnt reaches DEAD, go to IDLE.
- `detect` is cleared on the next ena=1 cycle after it was set. It is therefore high for exactly one enabled cycle, matching the downstream register's ena gating.
- `peak` and `peak_pos` change only when `detect` is set.

## Timing
- Reset values: detect=0, peak=0, peak_pos=0, busy=0, state IDLE, pos=0, all internal counters 0.
- Reset asserted mid-TRACK or mid-HOLDOFF aborts without a strobe. The partial maximum is discarded.
- Latency: `detect` rises on the clock edge that consumes the HOLD-th non-improving sample. It is visible in the following cycle.
- Minimum peak spacing: HOLD + DEAD + 1 valid samples after the arming sample.
- in_vld may be high every cycle or sparse. Gaps with in_vld=0 do not advance hold, dead or pos.
- ena=0 freezes everything, including a pending high `detect`.
- A threshold change takes effect only in IDLE, never during TRACK or HOLDOFF.

## Test plan
- Basic peak, threshold=100, HOLD=4, DEAD=8, stream 0,50,120,300,250,200,150,90 (pos 0..7):
  - arms at pos 2
  - detect after pos 7 with peak=300, peak_pos=3
- Tie, stream 200,200,100,100,100 with threshold=150: peak=200, peak_pos=0, detect after the 5th sample.
- Holdoff, after a detect feed 8 samples of 500: no detect. The 9th sample of 500 re-arms, and detect follows 4 samples later with peak=500.
- Negative values, threshold=-50, stream -100,-40,-60,-70,-80,-90: peak=-40 at pos 1.
- ena/in_vld gaps:
  - Run the basic case with in_vld toggling 1/0 and ena low for 3 cycles mid-TRACK: same peak, peak_pos and strobe count.
  - `detect` stays high while ena=0 and clears on the first ena=1 cycle.
- Reset mid-TRACK after 300 is seen:
  - all outputs 0 and no detect
  - a following stream gives pos restarting at 0
